// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host keyboard receiver: synchronise, deglitch ps2_clk, deframe, raise kbd_intr.
// Optional build macro PS2_PARITY_CHK_EN enables the odd-parity check on every received frame.
module ps2_kbd_rx #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYCS = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       intr_ack,
    output logic [7:0] scancode,
    output logic       kbd_intr,
    output logic       overrun,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCS + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic            r_clk_s1, r_clk_s2;
    logic            r_dat_s1, r_dat_s2;
    logic            r_clk_filt;
    logic [FW-1:0]   r_flt_cnt;
    logic            r_fall;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_sh;
    logic [TW-1:0]   r_to_cnt;
    logic            w_par_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered level only moves after FILTER_LEN consecutive differing samples;
    // the fall strobe is registered so it lines up with the already-synchronised data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 != r_clk_filt) begin
                if (r_flt_cnt == FLT_MAX) begin
                    r_clk_filt <= r_clk_s2;
                    r_flt_cnt  <= '0;
                    r_fall     <= r_clk_filt;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 1'b1;
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_fall && (r_state == S_DATA)) begin
            r_sh[r_bit_cnt] <= r_dat_s2;
        end
    end

`ifdef PS2_PARITY_CHK_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (r_fall && (r_state == S_PARITY)) begin
            r_par <= r_dat_s2;
        end
    end

    assign w_par_ok = ^{r_sh, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            scancode  <= '0;
            kbd_intr  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (intr_ack) begin
                kbd_intr  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (r_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        // An ack in the same cycle frees the slot, so the new byte is taken.
                        if (r_dat_s2 && w_par_ok) begin
                            if (!kbd_intr || intr_ack) begin
                                scancode <= r_sh;
                                kbd_intr <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_MAX) begin
                    r_state   <= S_IDLE;
                    r_to_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: framing, overrun, parity/stop errors, timeout, glitches, reset.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FLT = 8;
    localparam int TO  = 400;
    localparam int HP  = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       intr_ack;
    logic [7:0] scancode;
    logic       kbd_intr;
    logic       overrun;
    logic       frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wait;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FILTER_LEN   (FLT),
        .TIMEOUT_CYCS (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .intr_ack  (intr_ack),
        .scancode  (scancode),
        .kbd_intr  (kbd_intr),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        tick(HP / 2);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
        if (glitch) begin
            tick(4);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(HP / 2 - 7);
        end else begin
            tick(HP / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, ~(^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
        ps2_data = 1'b1;
    endtask

    // Stop bit with cycle-exact look at kbd_intr around the commit edge.
    task automatic stop_bit(input bit ack, input logic pre_exp);
        ps2_data = 1'b1;
        tick(HP / 2);
        ps2_clk = 1'b0;
        tick(FLT + 2);
        check("pre_commit_intr", 32'(kbd_intr), 32'(pre_exp));
        intr_ack = ack;
        tick(1);
        intr_ack = 1'b0;
    endtask

    task automatic stop_tail();
        tick(HP - FLT - 3);
        ps2_clk = 1'b1;
        tick(HP / 2);
    endtask

    task automatic do_ack();
        intr_ack = 1'b1;
        tick(1);
        intr_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; intr_ack = 1'b0;
        tick(4);
        check("rst_code", 32'(scancode), 32'h0);
        check("rst_intr", 32'(kbd_intr), 32'd0);
        check("rst_ovr",  32'(overrun),  32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick(4);

        // 1: good frame, exact commit latency, then ack
        send_frame(8'h1C, 1'b0, 1'b1, 10, 1'b0);
        stop_bit(1'b0, 1'b0);
        check("t1_intr", 32'(kbd_intr), 32'd1);
        check("t1_code", 32'(scancode), 32'h1C);
        check("t1_ferr", 32'(frame_err), 32'd0);
        stop_tail();
        do_ack();
        check("t1_ack_intr", 32'(kbd_intr), 32'd0);
        check("t1_ack_code", 32'(scancode), 32'h1C);

        // 2: overrun
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        check("t2_code", 32'(scancode), 32'h1C);
        check("t2_ovr",  32'(overrun),  32'd1);
        check("t2_intr", 32'(kbd_intr), 32'd1);
        do_ack();
        check("t2_ack_ovr",  32'(overrun),  32'd0);
        check("t2_ack_intr", 32'(kbd_intr), 32'd0);

        // 2b: ack coincides with commit of a new byte
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 10, 1'b0);
        stop_bit(1'b1, 1'b1);
        check("t2b_code", 32'(scancode), 32'h5A);
        check("t2b_intr", 32'(kbd_intr), 32'd1);
        check("t2b_ovr",  32'(overrun),  32'd0);
        stop_tail();
        do_ack();

        // 3: wrong parity bit
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHK_EN
        check("t3_ferr", 32'(frame_err), 32'd1);
        check("t3_intr", 32'(kbd_intr), 32'd0);
        check("t3_code", 32'(scancode), 32'h5A);
`else
        check("t3_ferr", 32'(frame_err), 32'd0);
        check("t3_intr", 32'(kbd_intr), 32'd1);
        check("t3_code", 32'(scancode), 32'h1C);
`endif
        do_ack();
        check("t3_ack_ferr", 32'(frame_err), 32'd0);

        // 4: bad stop bit, then a good frame
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_intr", 32'(kbd_intr), 32'd0);
        do_ack();
        check("t4_ack_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
        check("t4_code", 32'(scancode), 32'h32);
        check("t4_intr", 32'(kbd_intr), 32'd1);
        do_ack();

        // 5: clock stops after four data bits
        send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
        ps2_data = 1'b0;
        tick(HP / 2);
        ps2_clk = 1'b0;
        n_wait = 0;
        while (frame_err !== 1'b1 && n_wait < TO + FLT + 60) begin
            tick(1);
            n_wait++;
            if (n_wait == HP) ps2_clk = 1'b1;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        check("t5_to_lat", 32'(n_wait), 32'(TO + FLT + 3));
        check("t5_intr", 32'(kbd_intr), 32'd0);
        do_ack();
        tick(HP);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        check("t5_code", 32'(scancode), 32'h5A);
        check("t5_intr", 32'(kbd_intr), 32'd1);
        check("t5_ferr", 32'(frame_err), 32'd0);
        do_ack();

        // 6: glitched clock, then reset mid-frame
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b1);
        check("t6_glitch_code", 32'(scancode), 32'h29);
        check("t6_glitch_intr", 32'(kbd_intr), 32'd1);
        check("t6_glitch_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h77, 1'b0, 1'b1, 6, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("t6_rst_code", 32'(scancode), 32'h0);
        check("t6_rst_intr", 32'(kbd_intr), 32'd0);
        check("t6_rst_ovr",  32'(overrun),  32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
        check("t6_code", 32'(scancode), 32'h29);
        check("t6_intr", 32'(kbd_intr), 32'd1);
        check("t6_ferr", 32'(frame_err), 32'd0);
        check("t6_ovr",  32'(overrun),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
